// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging N stb/ack requester streams onto one output stream.
// Each transfer walks IDLE -> ACCEPT -> SEND; every output comes straight from a register.
module stream_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    localparam int GW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_stb,
    output logic [N-1:0]       in_ack,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_stb,
    input  logic               out_ack,
    output logic [GW-1:0]      grant,
    output logic               busy,
    input  logic [N-1:0]       port_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [GW-1:0]      ptr_r, ptr_s;
    logic [GW-1:0]      grant_r, grant_s;
    logic [N-1:0]       in_ack_r, in_ack_s;
    logic               out_stb_r, out_stb_s;
    logic [WIDTH-1:0]   out_data_r, out_data_s;
    logic               busy_r, busy_s;
    logic [N-1:0]       elig_s;
    logic [GW-1:0]      winner_s;

    // First set bit of elig found scanning upward from ptr, wrapping at N.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] elig, input logic [GW-1:0] ptr);
        logic [GW-1:0] win;
        logic          found;
        int            idx;
        win   = {GW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            idx = (idx >= N) ? idx - N : idx;
            if (!found && elig[idx]) begin
                win   = GW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Eligibility and round-robin winner for the IDLE selection.
    always_comb begin
        elig_s   = in_stb & port_mask;
        winner_s = rr_pick(elig_s, ptr_r);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        grant_s    = grant_r;
        in_ack_s   = {N{1'b0}};
        out_stb_s  = 1'b0;
        out_data_s = out_data_r;
        case (state_r)
            IDLE: begin
                if (elig_s != {N{1'b0}}) begin
                    state_s  = ACCEPT;
                    grant_s  = winner_s;
                    in_ack_s = {{(N-1){1'b0}}, 1'b1} << winner_s;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACCEPT: begin
                state_s    = SEND;
                out_stb_s  = 1'b1;
                out_data_s = in_data[int'(grant_r)*WIDTH +: WIDTH];
            end
            SEND: begin
                // out_ack only matters here; elsewhere it is never looked at.
                if (out_ack) begin
                    state_s = IDLE;
                    ptr_s   = (grant_r == GW'(N-1)) ? {GW{1'b0}} : grant_r + GW'(1);
                end else begin
                    out_stb_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            ptr_r      <= {GW{1'b0}};
            grant_r    <= {GW{1'b0}};
            in_ack_r   <= {N{1'b0}};
            out_stb_r  <= 1'b0;
            out_data_r <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            grant_r    <= grant_s;
            in_ack_r   <= in_ack_s;
            out_stb_r  <= out_stb_s;
            out_data_r <= out_data_s;
            busy_r     <= busy_s;
        end
    end

    assign in_ack   = in_ack_r;
    assign out_stb  = out_stb_r;
    assign out_data = out_data_r;
    assign grant    = grant_r;
    assign busy     = busy_r;

endmodule
